// File: rtl/klt_flow_solver_if.sv
// Result bus between the KLT integrator (master) and the flow solver (slave).
// Handshake: there is no ready. A rising edge of data_valid presents a new G/b set,
// which the solver samples only while idle. flow_valid is a one-cycle pulse
// qualifying dx/dy/singular/saturated, and these hold until the next pulse.
interface klt_flow_solver_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 16
);
  logic              data_valid;
  logic [IN_W-1:0]   G11;
  logic [IN_W-1:0]   G12;
  logic [IN_W-1:0]   G21;
  logic [IN_W-1:0]   G22;
  logic [IN_W-1:0]   b1;
  logic [IN_W-1:0]   b2;
  logic              busy;
  logic              flow_valid;
  logic [OUT_W-1:0]  dx;
  logic [OUT_W-1:0]  dy;
  logic              singular;
  logic              saturated;
  logic              overrun;

  modport master (
    output data_valid, G11, G12, G21, G22, b1, b2,
    input  busy, flow_valid, dx, dy, singular, saturated, overrun
  );

  modport slave (
    input  data_valid, G11, G12, G21, G22, b1, b2,
    output busy, flow_valid, dx, dy, singular, saturated, overrun
  );
endinterface

// File: rtl/klt_flow_solver.sv
// Solves the 2x2 KLT system d = G^-1 * b in fixed point, using one shared
// restoring divider that produces one quotient bit per cycle for dx, then dy.
module klt_flow_solver #(
  parameter int IN_W      = 26,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8,
  parameter int MIN_DET   = 1
) (
  input  logic             clk,
  input  logic             rst,
  klt_flow_solver_if.slave bus,
  output logic [2:0]       dbg_state
);
  localparam int PW    = 2 * IN_W + 1;
  localparam int CW    = 2 * IN_W + 2;
  localparam int QW    = OUT_W - 1;
  localparam int DW    = CW + QW;
  localparam int CNT_W = $clog2(QW + 1);
  localparam logic [CNT_W-1:0]     LAST      = CNT_W'(QW - 1);
  localparam logic signed [CW-1:0] MIN_DET_C = CW'(MIN_DET);
  localparam logic [QW-1:0]        Q_MAX     = '1;

  typedef enum logic [2:0] {IDLE, PROD, COMB, CHECK, DIVX, DIVY, DONE} state_t;

  state_t                 state;
  logic                   dv_q;
  logic [IN_W-1:0]        g11_r, g12_r, g22_r, b1_r, b2_r;
  logic signed [PW-1:0]   p_g11g22, p_g12g12, p_g22b1, p_g12b2, p_g11b2, p_g12b1;
  logic signed [CW-1:0]   det_r, numx_r, numy_r;
  logic [DW-1:0]          rem, rem_y, dsh;
  logic [QW-1:0]          q;
  logic [CNT_W-1:0]       cnt;
  logic                   neg_x, neg_y, sat_x, sat_y, sing_r;
  logic [OUT_W-1:0]       rx, ry;

  logic                   trig;
  logic signed [PW-1:0]   g11_e, g12_e, g22_e, b1_e, b2_e;
  logic [CW-1:0]          abs_x, abs_y;
  logic [DW-1:0]          num_sh_x, num_sh_y, den_sat, dsh_init, rem_n;
  logic                   ge;
  logic [QW-1:0]          q_n;
  logic                   unused_g21;

  assign trig       = bus.data_valid & ~dv_q;
  assign dbg_state  = state;
  assign unused_g21 = ^bus.G21;

  always_comb begin
    g11_e    = {{(PW-IN_W){1'b0}}, g11_r};
    g22_e    = {{(PW-IN_W){1'b0}}, g22_r};
    g12_e    = {{(PW-IN_W){g12_r[IN_W-1]}}, g12_r};
    b1_e     = {{(PW-IN_W){b1_r[IN_W-1]}}, b1_r};
    b2_e     = {{(PW-IN_W){b2_r[IN_W-1]}}, b2_r};
    abs_x    = numx_r[CW-1] ? -numx_r : numx_r;
    abs_y    = numy_r[CW-1] ? -numy_r : numy_r;
    num_sh_x = DW'({abs_x, {FRAC_BITS{1'b0}}});
    num_sh_y = DW'({abs_y, {FRAC_BITS{1'b0}}});
    // |num|*2^F >= det*2^(OUT_W-1) means the quotient cannot fit in OUT_W-1 bits
    den_sat  = {det_r, {QW{1'b0}}};
    dsh_init = DW'({det_r, {(QW-1){1'b0}}});
    ge       = rem >= dsh;
    rem_n    = ge ? rem - dsh : rem;
    q_n      = {q[QW-2:0], ge};
  end

  function automatic logic [OUT_W-1:0] signed_result(input logic [QW-1:0] mag,
                                                     input logic neg);
    logic [OUT_W-1:0] m;
    m = {1'b0, mag};
    return neg ? -m : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      dv_q           <= 1'b1;
      bus.busy       <= 1'b0;
      bus.flow_valid <= 1'b0;
      bus.dx         <= '0;
      bus.dy         <= '0;
      bus.singular   <= 1'b0;
      bus.saturated  <= 1'b0;
      bus.overrun    <= 1'b0;
      g11_r <= '0; g12_r <= '0; g22_r <= '0; b1_r <= '0; b2_r <= '0;
      p_g11g22 <= '0; p_g12g12 <= '0; p_g22b1 <= '0;
      p_g12b2  <= '0; p_g11b2  <= '0; p_g12b1 <= '0;
      det_r <= '0; numx_r <= '0; numy_r <= '0;
      rem <= '0; rem_y <= '0; dsh <= '0; q <= '0; cnt <= '0;
      neg_x <= 1'b0; neg_y <= 1'b0; sat_x <= 1'b0; sat_y <= 1'b0; sing_r <= 1'b0;
      rx <= '0; ry <= '0;
    end else begin
      dv_q           <= bus.data_valid;
      bus.flow_valid <= 1'b0;
      if (trig && state != IDLE) bus.overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (trig) begin
            g11_r    <= bus.G11;
            g12_r    <= bus.G12;
            g22_r    <= bus.G22;
            b1_r     <= bus.b1;
            b2_r     <= bus.b2;
            bus.busy <= 1'b1;
            state    <= PROD;
          end
        end
        PROD: begin
          p_g11g22 <= g11_e * g22_e;
          p_g12g12 <= g12_e * g12_e;
          p_g22b1  <= g22_e * b1_e;
          p_g12b2  <= g12_e * b2_e;
          p_g11b2  <= g11_e * b2_e;
          p_g12b1  <= g12_e * b1_e;
          state    <= COMB;
        end
        COMB: begin
          det_r  <= CW'(p_g11g22) - CW'(p_g12g12);
          numx_r <= CW'(p_g22b1) - CW'(p_g12b2);
          numy_r <= CW'(p_g11b2) - CW'(p_g12b1);
          state  <= CHECK;
        end
        CHECK: begin
          if (det_r < MIN_DET_C) begin
            sing_r <= 1'b1;
            sat_x  <= 1'b0;
            sat_y  <= 1'b0;
            rx     <= '0;
            ry     <= '0;
            state  <= DONE;
          end else begin
            sing_r <= 1'b0;
            sat_x  <= num_sh_x >= den_sat;
            sat_y  <= num_sh_y >= den_sat;
            neg_x  <= numx_r[CW-1];
            neg_y  <= numy_r[CW-1];
            rem    <= num_sh_x;
            rem_y  <= num_sh_y;
            dsh    <= dsh_init;
            q      <= '0;
            cnt    <= '0;
            state  <= DIVX;
          end
        end
        DIVX, DIVY: begin
          rem <= rem_n;
          dsh <= dsh >> 1;
          q   <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt <= '0;
            q   <= '0;
            if (state == DIVX) begin
              rx    <= signed_result(sat_x ? Q_MAX : q_n, neg_x);
              rem   <= rem_y;
              dsh   <= dsh_init;
              state <= DIVY;
            end else begin
              ry    <= signed_result(sat_y ? Q_MAX : q_n, neg_y);
              state <= DONE;
            end
          end
        end
        DONE: begin
          bus.dx         <= rx;
          bus.dy         <= ry;
          bus.singular   <= sing_r;
          bus.saturated  <= sat_x | sat_y;
          bus.flow_valid <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_klt_flow_solver.sv
// Directed bench for klt_flow_solver: hand-computed solves, latency, overrun and
// reset-while-solving behaviour, checked through one compare task.
module tb_klt_flow_solver;
  localparam int IN_W   = 26;
  localparam int OUT_W  = 16;
  localparam int L_NORM = 34;
  localparam int L_SING = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [33:0] exp_q[$];  // {singular, saturated, dx, dy}

  klt_flow_solver_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  klt_flow_solver #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC_BITS(8), .MIN_DET(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_inputs(input int g11, input int g12, input int g22,
                            input int b1, input int b2);
    bus.G11 = IN_W'(g11);
    bus.G12 = IN_W'(g12);
    bus.G21 = IN_W'(g12);
    bus.G22 = IN_W'(g22);
    bus.b1  = IN_W'(b1);
    bus.b2  = IN_W'(b2);
  endtask

  // Called with data_valid just raised at a negedge; index 0 is the trigger edge.
  // Optionally drops/re-raises data_valid mid-solve. lat = -1 on timeout.
  task automatic wait_flow(input string tag, input int drop_at, input int raise_at,
                           output int lat);
    lat = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) check({tag, "_busy_start"}, bus.busy, 1);
      if (cyc == 1) set_inputs($urandom_range(1, 1000), $urandom_range(0, 50),
                               $urandom_range(1, 1000), $urandom_range(0, 9999),
                               $urandom_range(0, 9999));
      if (cyc == drop_at) bus.data_valid = 1'b0;
      if (cyc == raise_at) bus.data_valid = 1'b1;
      if (bus.flow_valid) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat);
    logic [33:0] e;
    check({tag, "_latency"}, lat, exp_lat);
    if (lat < 0) return;
    e = exp_q.pop_front();
    check({tag, "_busy_done"}, bus.busy, 0);
    check({tag, "_dx"}, $signed(bus.dx), $signed(e[31:16]));
    check({tag, "_dy"}, $signed(bus.dy), $signed(e[15:0]));
    check({tag, "_singular"}, bus.singular, e[33]);
    check({tag, "_saturated"}, bus.saturated, e[32]);
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, bus.flow_valid, 0);
  endtask

  task automatic run_solve(input string tag, input int g11, input int g12, input int g22,
                           input int b1, input int b2, input int exp_dx, input int exp_dy,
                           input bit exp_sing, input bit exp_sat, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.data_valid = 1'b0;
    set_inputs(g11, g12, g22, b1, b2);
    @(negedge clk);
    bus.data_valid = 1'b1;
    exp_q.push_back({exp_sing, exp_sat, 16'(exp_dx), 16'(exp_dy)});
    wait_flow(tag, -1, -1, lat);
    check_result(tag, lat, exp_lat);
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic count_flow(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (bus.flow_valid) seen++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    bus.data_valid = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_flow_valid", bus.flow_valid, 0);
    check("rst_dx", bus.dx, 0);
    check("rst_dy", bus.dy, 0);
    check("rst_singular", bus.singular, 0);
    check("rst_saturated", bus.saturated, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_solve("basic",  4,  0,  4,    8,    -4,    512,   -256, 0, 0, L_NORM);
    run_solve("trunc",  3,  0,  3,    1,    -1,     85,    -85, 0, 0, L_NORM);
    run_solve("cross",  2, -1,  2,    3,     1,    597,    426, 0, 0, L_NORM);
    run_solve("sing",   1,  1,  1,   77,   -55,      0,      0, 1, 0, L_SING);
    run_solve("sat",    1,  0,  1, 1000, -1000,  32767, -32767, 0, 1, L_NORM);
    run_solve("satedge", 16, 0, 16, 2048,  2047,  32767,  32752, 0, 1, L_NORM);

    repeat (5) @(posedge clk);
    #1;
    check("hold_dx", $signed(bus.dx), 32767);
    check("hold_dy", $signed(bus.dy), 32752);
    check("no_overrun_yet", bus.overrun, 0);

    // Overrun: a second edge at cycle 10 of a solve is ignored but flagged.
    @(negedge clk);
    bus.data_valid = 1'b0;
    set_inputs(4, 0, 4, 8, -4);
    @(negedge clk);
    bus.data_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'(512), 16'(-256)});
    wait_flow("ovr", 5, 10, lat);
    check("ovr_flag_set", bus.overrun, 1);
    check_result("ovr", lat, L_NORM);
    count_flow(60, seen);
    check("ovr_no_second_flow", seen, 0);
    check("ovr_sticky", bus.overrun, 1);

    // Reset during DIVX with data_valid held high.
    @(negedge clk);
    bus.data_valid = 1'b0;
    set_inputs(3, 0, 3, 1, -1);
    @(negedge clk);
    bus.data_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_dx", bus.dx, 0);
    check("mid_rst_dy", bus.dy, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_flow(60, seen);
    check("post_rst_no_flow", seen, 0);
    check("post_rst_busy", bus.busy, 0);
    run_solve("after_rst", 3, 0, 3, 1, -1, 85, -85, 0, 0, L_NORM);
    check("after_rst_overrun", bus.overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/klt_flow_solver.md
# klt_flow_solver

Consumer of the KLT integrator's result bus. On each new `data_valid` it latches G11, G12, G22, b1 and b2, and computes the flow update d = G⁻¹·b in signed fixed point:
- dx = (G22·b1 − G12·b2)/det
- dy = (G11·b2 − G12·b1)/det
- det = G11·G22 − G12²

Division is an iterative restoring divider, so the block is small and multi-cycle. It sits between the integrator and the per-feature position update logic.

## Interface
- `IN_W`, 26: width of G/b inputs.
- `OUT_W`, 16: width of dx/dy (signed two's complement).
- `FRAC_BITS`, 8: fractional bits of dx/dy.
- `MIN_DET`, 1: any det below this is treated as singular.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_valid`  in  1  level from integrator; rising edge = new result.
- `G11`  in  IN_W  unsigned Σ Ix².
- `G12`  in  IN_W  signed Σ Ix·Iy.
- `G21`  in  IN_W  unused; equals G12 by construction.
- `G22`  in  IN_W  unsigned Σ Iy².
- `b1`  in  IN_W  signed Σ dI·Ix.
- `b2`  in  IN_W  signed Σ dI·Iy.
- `busy`  out  1  solve in progress.
- `flow_valid`  out  1  one-cycle pulse, dx/dy/flags valid.
- `dx`  out  OUT_W  signed Q(OUT_W−FRAC_BITS).FRAC_BITS.
- `dy`  out  OUT_W  same format as dx.
- `singular`  out  1  det < MIN_DET for last result.
- `saturated`  out  1  dx or dy clipped for last result.
- `overrun`  out  1  sticky; rising edge arrived while busy.

## Operation
- **Edge detection.** `dv_q` is `data_valid` registered. A trigger is `data_valid & ~dv_q` and is acted on only in IDLE.
  - `dv_q` resets to 1, so a level still held high across reset does not retrigger.
- **States:** IDLE → PROD → COMB → CHECK → DIVX → DIVY → DONE → IDLE.
- **IDLE.** On trigger, latch the inputs, set `busy`=1 and go to PROD.
- **PROD.** Register the six products (G11·G22, G12·G12, G22·b1, G12·b2, G11·b2, G12·b1) at 2·IN_W+1 bits, signed.
- **COMB.** Register det, numx and numy at 2·IN_W+2 bits, signed, with no overflow possible.
- **CHECK.**
  - If det < MIN_DET (signed compare): singular=1, dx=dy=0, saturated=0, go to DONE.
  - Otherwise go to DIVX.
- **DIVX / DIVY.** Each is OUT_W−1 cycles.
  - Compute q = floor(|num|·2^FRAC_BITS / det), one quotient bit per cycle, MSB first.
  - If |num|·2^FRAC_BITS ≥ det·2^(OUT_W−1), q = 2^(OUT_W−1)−1 and saturated=1.
  - Apply the sign of num: result = ±q. Rounding is truncation toward zero, and saturation is symmetric (never −2^(OUT_W−1)).
- **DONE.** Register dx, dy, singular and saturated; pulse `flow_valid`; clear `busy`; return to IDLE.
- **Output hold.** dx, dy, singular and saturated hold their values until the next DONE.
- **Overrun.** A trigger edge while `busy` is ignored and sets `overrun`, which clears only on `rst`.
- **Reset.** `rst` asserted in any state:
  - Immediately: state=IDLE, and all outputs plus `overrun` = 0.
  - The solve in progress is discarded and no `flow_valid` is produced.

## Timing
- **Normal latency.** For a trigger sampled at edge k, `flow_valid` is high for exactly the cycle after edge k+L, where L = 4 + 2·(OUT_W−1). With defaults, L = 34.
- **Singular latency.** L = 4.
- **Busy window.** `busy` is high from edge k through edge k+L; it is low in the `flow_valid` cycle.
- **Back-to-back.** A new trigger is accepted in the cycle `flow_valid` is high, because state is IDLE.
- **Throughput.** One solve per L+1 cycles, maximum.
- **Simultaneous events.** A trigger in the DONE cycle counts as busy, so it is an overrun.
- **Input stability.** Inputs are sampled only at the trigger edge; later changes during the solve have no effect.

## Test plan
- **Basic solve.** G11=4, G12=0, G22=4, b1=8, b2=−4, FRAC_BITS=8 → after 34 cycles: dx=512 (0x0200), dy=−256 (0xFF00), singular=0, saturated=0, one-cycle `flow_valid`.
- **Truncation.** G11=3, G22=3, G12=0, b1=1, b2=−1 → dx=85, dy=−85 (toward zero).
- **Singular.** G11=G12=G22=1, any b → det=0 → `flow_valid` 4 cycles after the trigger, singular=1, dx=dy=0.
- **Saturation.** G11=G22=1, G12=0, b1=1000, b2=−1000 → dx=32767, dy=−32767, saturated=1.
- **Overrun.** Drop `data_valid`, re-raise it at cycle 10 of a solve → first result unaffected, `overrun`=1 (sticky), no second `flow_valid`.
- **Reset mid-solve.** `rst` asserted during DIVX with `data_valid` held high → all outputs 0 immediately, no `flow_valid` after release until `data_valid` falls and rises again.
